// File: rtl/perf_lat_bw_monitor.sv
// perf_lat_bw_monitor: per-channel transaction latency statistics and windowed bandwidth counters
module perf_lat_bw_monitor #(
  parameter int NUM_CH  = 4,
  parameter int ID_W    = 4,
  parameter int TS_W    = 16,
  parameter int CNT_W   = 32,
  parameter int BYTES_W = 8,
  parameter int WIN_CYC = 1024,
  localparam int RCW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req_vld,
  input  logic [NUM_CH*ID_W-1:0]    req_id,
  input  logic [NUM_CH*BYTES_W-1:0] req_bytes,
  input  logic [NUM_CH-1:0]         rsp_vld,
  input  logic [NUM_CH*ID_W-1:0]    rsp_id,
  input  logic                      clr,
  input  logic [RCW-1:0]            rd_ch,
  input  logic [2:0]                rd_sel,
  output logic [CNT_W-1:0]          rd_data,
  output logic [NUM_CH-1:0]         err,
  output logic                      win_done
);
  localparam int NID = 1 << ID_W;
  localparam int WW  = $clog2(WIN_CYC);

  logic [TS_W-1:0] ts_q, ts_d;
  logic [WW-1:0] win_q, win_d;
  logic [NUM_CH-1:0][NID-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0][NID-1:0][TS_W-1:0] tstab_q, tstab_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, sum_q, sum_d, min_q, min_d, max_q, max_d;
  logic [NUM_CH-1:0][CNT_W-1:0] ecnt_q, ecnt_d, acc_q, acc_d, last_q, last_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic win_done_q, win_done_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic wrap;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // next-state: retire responses before allocating requests, accumulate bytes, clear on clr
  always_comb begin
    ts_d = ts_q + 1'b1;
    wrap = win_q == WW'(WIN_CYC - 1);
    win_d = wrap ? '0 : win_q + 1'b1;
    win_done_d = wrap;
    busy_d = busy_q;
    tstab_d = tstab_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    ecnt_d = ecnt_q;
    acc_d = acc_q;
    last_d = last_q;
    err_d = err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [ID_W-1:0] rid, qid;
      logic [TS_W-1:0] lat;
      logic rsp_ok, req_ok;
      logic [CNT_W-1:0] nerr, acc_sum;
      rid = rsp_id[c*ID_W +: ID_W];
      qid = req_id[c*ID_W +: ID_W];
      rsp_ok = busy_q[c][rid];
      lat = ts_q - tstab_q[c][rid];
      if (rsp_vld[c] && rsp_ok) begin
        busy_d[c][rid] = 1'b0;
        cnt_d[c] = sat_add(cnt_q[c], CNT_W'(1));
        sum_d[c] = sat_add(sum_q[c], CNT_W'(lat));
        min_d[c] = CNT_W'(lat) < min_q[c] ? CNT_W'(lat) : min_q[c];
        max_d[c] = CNT_W'(lat) > max_q[c] ? CNT_W'(lat) : max_q[c];
      end
      req_ok = !busy_d[c][qid];
      if (req_vld[c] && req_ok) begin
        busy_d[c][qid] = 1'b1;
        tstab_d[c][qid] = ts_q;
      end
      nerr = CNT_W'(rsp_vld[c] && !rsp_ok) + CNT_W'(req_vld[c] && !req_ok);
      ecnt_d[c] = sat_add(ecnt_q[c], nerr);
      err_d[c] = err_q[c] | (nerr != '0);
      acc_sum = sat_add(acc_q[c], req_vld[c] ? CNT_W'(req_bytes[c*BYTES_W +: BYTES_W]) : '0);
      last_d[c] = wrap ? acc_sum : last_q[c];
      acc_d[c] = wrap ? '0 : acc_sum;
    end
    if (clr) begin
      win_d = '0;
      win_done_d = 1'b0;
      busy_d = '0;
      cnt_d = '0;
      sum_d = '0;
      min_d = '1;
      max_d = '0;
      ecnt_d = '0;
      acc_d = '0;
      last_d = '0;
      err_d = '0;
    end
  end

  // readout mux selecting one statistic of one channel
  always_comb begin
    rd_data_d = int'(rd_ch) >= NUM_CH ? '0 :
                rd_sel == 3'd0 ? cnt_q[rd_ch] :
                rd_sel == 3'd1 ? sum_q[rd_ch] :
                rd_sel == 3'd2 ? min_q[rd_ch] :
                rd_sel == 3'd3 ? max_q[rd_ch] :
                rd_sel == 3'd4 ? last_q[rd_ch] :
                rd_sel == 3'd5 ? ecnt_q[rd_ch] : '0;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
      win_q <= '0;
      busy_q <= '0;
      tstab_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
      ecnt_q <= '0;
      acc_q <= '0;
      last_q <= '0;
      err_q <= '0;
      win_done_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      ts_q <= ts_d;
      win_q <= win_d;
      busy_q <= busy_d;
      tstab_q <= tstab_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
      ecnt_q <= ecnt_d;
      acc_q <= acc_d;
      last_q <= last_d;
      err_q <= err_d;
      win_done_q <= win_done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign err = err_q;
  assign win_done = win_done_q;
endmodule

// File: doc/perf_lat_bw_monitor.md
PERF_LAT_BW_MONITOR -- requirements
Module: perf_lat_bw_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent monitored channels (1..16).
REQ-002 Parameter ID_W, default 4: transaction ID width; each channel tracks 2^ID_W outstanding IDs.
REQ-003 Parameter TS_W, default 16: free-running timestamp width; latency is measured modulo 2^TS_W.
REQ-004 Parameter CNT_W, default 32: width of every statistic counter and of rd_data.
REQ-005 Parameter BYTES_W, default 8: per-request byte-count width.
REQ-006 Parameter WIN_CYC, default 1024: bandwidth window length in cycles (>= 2).
REQ-007 clk  in  1  single clock; all logic is on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 req_vld  in  NUM_CH  per-channel request issue strobe.
REQ-010 req_id  in  NUM_CH*ID_W  request ID; channel c uses slice [c*ID_W +: ID_W].
REQ-011 req_bytes  in  NUM_CH*BYTES_W  request payload bytes; channel c uses slice [c*BYTES_W +: BYTES_W].
REQ-012 rsp_vld  in  NUM_CH  per-channel response (completion) strobe.
REQ-013 rsp_id  in  NUM_CH*ID_W  response ID, sliced as req_id.
REQ-014 clr  in  1  synchronous statistics clear.
REQ-015 rd_ch  in  max(1,$clog2(NUM_CH))  channel selected for readout.
REQ-016 rd_sel  in  3  statistic select: 0 count, 1 latency sum, 2 latency min, 3 latency max, 4 last-window bytes, 5 error count, 6-7 return 0.
REQ-017 rd_data  out  CNT_W  registered readout of the selected statistic.
REQ-018 err  out  NUM_CH  sticky per-channel protocol-error flag.
REQ-019 win_done  out  1  one-cycle pulse marking a new last-window value.

Function
REQ-020 The timestamp counter SHALL increment every cycle and wrap from 2^TS_W-1 to 0.
REQ-021 On req_vld[c] with the ID idle, the block SHALL mark the ID busy and store the current timestamp in that channel's table entry.
REQ-022 On rsp_vld[c] with the ID busy, the block SHALL compute latency = (ts_now - ts_start) mod 2^TS_W, zero-extended to CNT_W, and free the ID.
REQ-023 Latency statistics SHALL be visible to rd_data exactly 2 cycles after the response cycle: 1 cycle statistic register plus 1 cycle read register.
REQ-024 Each completed latency SHALL increment count, add to sum, lower min if smaller, and raise max if larger.
REQ-025 count, sum, byte accumulators and error count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 min SHALL hold all-ones and max SHALL hold 0 until the first completion.
REQ-027 A req_vld on an already-busy ID SHALL set err[c], increment the error count, and leave the stored timestamp unchanged.
REQ-028 A rsp_vld on an idle ID SHALL set err[c], increment the error count, and leave all latency statistics unchanged.
REQ-029 With req_vld and rsp_vld on the same channel and same ID in one cycle, the response SHALL retire the old entry first and the request SHALL then allocate with the current timestamp, with no error.
REQ-030 With req_vld and rsp_vld on different IDs of one channel in one cycle, both SHALL be processed independently.
REQ-031 A bad request and a bad response on one channel in the same cycle SHALL increment the error count by 2.
REQ-032 The window counter SHALL count 0..WIN_CYC-1 and then wrap.
REQ-033 req_bytes of every accepted or erroring request SHALL be added to the channel's window accumulator.
REQ-034 In the cycle the window counter equals WIN_CYC-1, the last-window register SHALL load the accumulator plus that cycle's bytes, and the accumulator SHALL load 0.
REQ-035 win_done SHALL assert in the cycle after the last-window load.
REQ-036 rd_data SHALL register the statistic selected by rd_ch and rd_sel, with 1-cycle latency.
REQ-037 An rd_ch value >= NUM_CH SHALL return 0.
REQ-038 clr SHALL act like reset on the ID tables, statistics, err, the window counter and the accumulators.
REQ-039 clr SHALL leave the timestamp counter running.
REQ-040 Any req_vld or rsp_vld in the clr cycle SHALL be ignored.

Reset
REQ-041 While reset is high, the block SHALL hold or force the following values:
- rd_data = 0, err = 0, win_done = 0;
- timestamp = 0, window counter = 0;
- all IDs idle;
- count, sum, max, error count, accumulators and last-window = 0;
- min = all-ones.
REQ-042 A reset asserted with transactions outstanding SHALL discard them; responses arriving after reset SHALL count as errors.

Verification
REQ-043 Ch0 req id 3 at t=10, rsp id 3 at t=25 -> then:
- sel0=1, sel1=15, sel2=15, sel3=15;
- err=0.
REQ-044 Ch1 req id 2 at ts=0xFFF0, rsp at ts=0x0010 (TS_W=16) -> latency 32, no error.
REQ-045 Ch0 req id 5 twice without rsp -> err[0]=1, sel5=1, latency on later rsp measured from first req.
REQ-046 WIN_CYC=8, ch2 req_bytes=4 every cycle from reset release -> win_done pulses every 8 cycles, sel4=32.
REQ-047 Same-cycle rsp+req on ch0 id 1 -> count+1, entry re-armed with current ts, err=0.
REQ-048 clr with 3 IDs outstanding, then rsp on one of them -> err set, count=0, min=all-ones.
